// File: rtl/uart_time_reporter.sv
// Formats a captured {digit_h, digit_l, dot} snapshot as "HH:LL\r\n" and streams it into the UART TX FIFO.
// Optional `UART_TIME_REPORT_AUTO_EN`: any change of {digit_h, digit_l} also acts as a report request.
module uart_time_reporter #(
    parameter logic [7:0] SEP_CHAR   = 8'h3A,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [6:0] digit_h,
    input  logic [6:0] digit_l,
    input  logic       dot,
    input  logic       fifo_full,
    output logic       fifo_wr,
    output logic [7:0] fifo_wr_data,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       pending_q, pending_d;
    logic [6:0] snap_h_q, snap_h_d;
    logic [6:0] snap_l_q, snap_l_d;
    logic       snap_dot_q, snap_dot_d;
    logic       trig;
    logic [7:0] bcd_h, bcd_l;
    logic [7:0] frame_byte;

    // Saturate to 99, then split into {tens, ones} nibbles with a compare chain.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] sat;
        logic [3:0] tens;
        logic [6:0] rem;
        sat  = (v > 7'd99) ? 7'd99 : v;
        tens = 4'd0;
        for (int k = 1; k < 10; k++) begin
            if (sat >= 7'(k * 10)) tens = 4'(k);
        end
        rem = sat - ({3'b000, tens} * 7'd10);
        return {tens, rem[3:0]};
    endfunction

`ifdef UART_TIME_REPORT_AUTO_EN
    logic [13:0] prev_q, prev_d;

    always_comb begin
        prev_d = {digit_h, digit_l};
        trig   = req | (prev_d != prev_q);
    end

    always_ff @(posedge clk) begin
        if (reset) prev_q <= 14'd0;
        else       prev_q <= prev_d;
    end
`else
    always_comb begin
        trig = req;
    end
`endif

    always_comb begin
        bcd_h = to_bcd(snap_h_q);
        bcd_l = to_bcd(snap_l_q);
        frame_byte = 8'h00;
        case (idx_q)
            3'd0:    frame_byte = {4'h3, bcd_h[7:4]};
            3'd1:    frame_byte = {4'h3, bcd_h[3:0]};
            3'd2:    frame_byte = snap_dot_q ? SEP_CHAR : BLANK_CHAR;
            3'd3:    frame_byte = {4'h3, bcd_l[7:4]};
            3'd4:    frame_byte = {4'h3, bcd_l[3:0]};
            3'd5:    frame_byte = 8'h0D;
            3'd6:    frame_byte = 8'h0A;
            default: frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        snap_h_d     = snap_h_q;
        snap_l_d     = snap_l_q;
        snap_dot_d   = snap_dot_q;
        fifo_wr      = 1'b0;
        fifo_wr_data = 8'h00;
        busy         = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig || pending_q) begin
                    snap_h_d   = digit_h;
                    snap_l_d   = digit_l;
                    snap_dot_d = dot;
                    pending_d  = 1'b0;
                    idx_d      = 3'd0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                busy         = 1'b1;
                fifo_wr      = !fifo_full;
                fifo_wr_data = frame_byte;
                // Requests during a frame collapse into a single follow-up frame.
                if (trig) pending_d = 1'b1;
                if (!fifo_full) begin
                    if (idx_q == 3'd6) begin
                        idx_d   = 3'd0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            pending_q  <= 1'b0;
            snap_h_q   <= 7'd0;
            snap_l_q   <= 7'd0;
            snap_dot_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            snap_h_q   <= snap_h_d;
            snap_l_q   <= snap_l_d;
            snap_dot_q <= snap_dot_d;
        end
    end

endmodule

// File: tb/tb_uart_time_reporter.sv
// Self-checking bench for uart_time_reporter: directed scenarios plus randomized frames vs. an arithmetic model.
module tb_uart_time_reporter;

    logic       clk = 1'b0;
    logic       reset, req, dot, fifo_full;
    logic [6:0] digit_h, digit_l;
    logic       fifo_wr, busy;
    logic [7:0] fifo_wr_data;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         busy_cnt = 0;
    int         full_cnt = 0;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];

    uart_time_reporter dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .digit_h      (digit_h),
        .digit_l      (digit_l),
        .dot          (dot),
        .fifo_full    (fifo_full),
        .fifo_wr      (fifo_wr),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_wr === 1'b1) begin
            got_q.push_back(fifo_wr_data);
            got_cyc.push_back(cyc);
        end
        if (busy === 1'b1) busy_cnt++;
        if (busy === 1'b1 && fifo_full === 1'b1) full_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        busy_cnt = 0;
        full_cnt = 0;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 0);
    endtask

    // Reference frame from plain arithmetic on the requested values.
    task automatic add_frame(input int h, input int l, input bit d);
        int hs, ls;
        hs = (h > 99) ? 99 : h;
        ls = (l > 99) ? 99 : l;
        exp_q.push_back(8'(48 + hs / 10));
        exp_q.push_back(8'(48 + hs % 10));
        exp_q.push_back(d ? 8'h3A : 8'h20);
        exp_q.push_back(8'(48 + ls / 10));
        exp_q.push_back(8'(48 + ls % 10));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic check_frames(input string tag);
        int n;
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req = 1'b0; dot = 1'b0; fifo_full = 1'b0;
        digit_h = 7'd0; digit_l = 7'd0;
        tick(3);
        chk("rst_wr", fifo_wr, 0);
        chk("rst_data", fifo_wr_data, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick(2);
        clr();

`ifndef UART_TIME_REPORT_AUTO_EN
        // Basic frame and latency
        digit_h = 7'd12; digit_l = 7'd34; dot = 1'b1;
        pulse_req();
        chk("basic_busy_n1", busy, 1);
        chk("basic_wr_n1", fifo_wr, 1);
        wait_idle(30);
        add_frame(12, 34, 1);
        check_frames("basic");
        chk("basic_busy_cnt", busy_cnt, 7);
        if (got_cyc.size() == 7) chk("basic_consec", got_cyc[6] - got_cyc[0], 6);
        tick(3);
        clr();

        // Blank separator and saturation
        digit_h = 7'd0; digit_l = 7'd105; dot = 1'b0;
        pulse_req();
        wait_idle(30);
        add_frame(0, 105, 0);
        check_frames("sat");
        tick(2);
        clr();

        // Backpressure at byte 2 for 3 cycles
        digit_h = 7'd56; digit_l = 7'd78; dot = 1'b1;
        pulse_req();
        tick(2);
        for (int k = 0; k < 3; k++) begin
            fifo_full = 1'b1;
            #1;
            chk($sformatf("bp_wr%0d", k), fifo_wr, 0);
            chk($sformatf("bp_data%0d", k), fifo_wr_data, 8'h3A);
            tick();
        end
        fifo_full = 1'b0;
        wait_idle(30);
        add_frame(56, 78, 1);
        check_frames("bp");
        chk("bp_busy_cnt", busy_cnt, 10);
        chk("bp_full_cnt", full_cnt, 3);
        tick(2);
        clr();

        // Pending requests collapse; inputs changed mid-frame
        digit_h = 7'd12; digit_l = 7'd34; dot = 1'b1;
        pulse_req();
        tick();
        pulse_req();
        pulse_req();
        digit_h = 7'd5; digit_l = 7'd6;
        tick();
        pulse_req();
        wait_idle(30);
        tick();
        chk("pend_gap_busy", busy, 1);
        wait_idle(30);
        tick(12);
        add_frame(12, 34, 1);
        add_frame(5, 6, 1);
        check_frames("pend");
        chk("pend_busy_cnt", busy_cnt, 14);
        if (got_cyc.size() == 14) chk("pend_gap", got_cyc[7] - got_cyc[6], 2);
        clr();

        // Request coincident with the byte 6 write
        digit_h = 7'd21; digit_l = 7'd43; dot = 1'b0;
        pulse_req();
        tick(6);
        pulse_req();
        digit_h = 7'd9; digit_l = 7'd10;
        wait_idle(30);
        tick();
        chk("lastreq_busy", busy, 1);
        wait_idle(30);
        tick(10);
        add_frame(21, 43, 0);
        add_frame(9, 10, 0);
        check_frames("lastreq");
        clr();

        // Reset mid-frame
        digit_h = 7'd12; digit_l = 7'd34; dot = 1'b1;
        pulse_req();
        tick(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_wr", fifo_wr, 0);
        chk("rstmid_busy", busy, 0);
        tick(8);
        exp_q.push_back(8'h31); exp_q.push_back(8'h32);
        exp_q.push_back(8'h3A); exp_q.push_back(8'h33);
        check_frames("rstmid");
        clr();
        digit_h = 7'd77; digit_l = 7'd88;
        pulse_req();
        wait_idle(30);
        add_frame(77, 88, 1);
        check_frames("rstnext");
        tick(2);
        clr();

        // Randomized frames with random backpressure and input churn
        for (int it = 0; it < 20; it++) begin
            int h, l;
            bit d;
            h = $urandom_range(0, 127);
            l = $urandom_range(0, 127);
            d = 1'($urandom_range(0, 1));
            digit_h = 7'(h); digit_l = 7'(l); dot = d;
            clr();
            pulse_req();
            for (int n = 0; n < 200 && busy === 1'b1; n++) begin
                fifo_full = ($urandom_range(0, 2) == 0);
                digit_h = 7'($urandom_range(0, 127));
                digit_l = 7'($urandom_range(0, 127));
                dot = 1'($urandom_range(0, 1));
                tick();
            end
            fifo_full = 1'b0;
            if (busy !== 1'b0) chk("rnd_timeout", 32'(busy), 0);
            tick(2);
            add_frame(h, l, d);
            check_frames($sformatf("rnd%0d", it));
            chk($sformatf("rnd%0d_len_cyc", it), busy_cnt, 7 + full_cnt);
        end
`else
        // Auto mode: a change of the inputs alone triggers a report
        dot = 1'b1;
        tick(5);
        chk("auto_quiet", got_q.size(), 0);
        digit_l = 7'd7;
        tick();
        wait_idle(30);
        tick(3);
        clr();
        digit_l = 7'd8;
        tick();
        chk("auto_busy", busy, 1);
        wait_idle(30);
        tick(20);
        add_frame(0, 8, 1);
        check_frames("auto");
        chk("auto_busy_cnt", busy_cnt, 7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_time_reporter.md
# uart_time_reporter

Formats the displayed watch/stopwatch value as an ASCII text frame and pushes it byte-by-byte into the UART TX FIFO. It sits downstream of `time_sel`, consuming `digit_h`, `digit_l` and `dot`, and sits upstream of the TX FIFO that feeds `uart`. A report starts on a one-cycle request pulse, typically issued by `FSM` on a received query command. Each frame is a consistent snapshot: all 7 bytes come from one captured value.

## Interface

Parameters:
- `SEP_CHAR`, 8'h3A (':'): separator byte sent when the captured `dot` is 1.
- `BLANK_CHAR`, 8'h20 (' '): separator byte sent when the captured `dot` is 0.

Ports:
- `clk`, input, 1: system clock; the only clock.
- `reset`, input, 1: synchronous, active-high reset.
- `req`, input, 1: one-cycle report request.
- `digit_h`, input, 7: upper display field, binary value 0..127.
- `digit_l`, input, 7: lower display field, binary value 0..127.
- `dot`, input, 1: display dot state.
- `fifo_full`, input, 1: TX FIFO full flag.
- `fifo_wr`, output, 1: TX FIFO write strobe.
- `fifo_wr_data`, output, 8: byte to write.
- `busy`, output, 1: high while a frame is being emitted.

## Operation

Frame format, bytes 0..6:
- Byte 0: tens(H), as ASCII.
- Byte 1: ones(H), as ASCII.
- Byte 2: the separator.
- Byte 3: tens(L), as ASCII.
- Byte 4: ones(L), as ASCII.
- Byte 5: 8'h0D.
- Byte 6: 8'h0A.

Arithmetic:
- Each field value v saturates to 99 when v > 99.
- tens = v/10 and ones = v%10, each output as 8'h30 + digit.
- Conversion is done on the captured snapshot. Either combinational or multicycle conversion is allowed, provided the timing below holds.

State machine:
- IDLE: `busy`=0, `fifo_wr`=0, `fifo_wr_data`=8'h00.
  - If `req`=1 or `pending`=1: capture `digit_h`, `digit_l`, `dot`; clear `pending`; clear byte index to 0; go to SEND.
- SEND: `busy`=1.
  - `fifo_wr` = !`fifo_full`.
  - `fifo_wr_data` = frame[index], valid whenever in SEND, stalled or not.
  - Index increments only when `fifo_wr`=1.
  - When byte 6 is written, go to IDLE.

Pending request:
- A `req` arriving in SEND sets the single-bit `pending` flag.
- Any number of requests during one frame collapse into one pending frame.
- A `req` in the same cycle as the byte 6 write also sets `pending`.

Other rules:
- Input changes during SEND do not affect the current frame.
- `reset` in any state, including mid-frame, forces IDLE, index 0, `pending`=0, and the snapshot to 0. The partial frame is abandoned; no completion bytes are sent.

## Timing

- `req` sampled high in IDLE at edge N: snapshot is captured at N, and `busy` and `fifo_wr` are high in cycle N+1.
- With `fifo_full` held 0, bytes 0..6 are written in cycles N+1..N+7 on consecutive edges. Back in IDLE at cycle N+8.
- Each cycle with `fifo_full`=1 during SEND extends the frame by exactly one cycle. No byte is dropped or duplicated.
- Pending frame: IDLE for exactly one cycle (N+8), capture at the end of N+8, next byte 0 in cycle N+9.
- Reset values: `fifo_wr`=0, `fifo_wr_data`=8'h00, `busy`=0.

## Configuration

- `UART_TIME_REPORT_AUTO_EN` defined:
  - Adds a 14-bit register `prev` = {`digit_h`,`digit_l`}, reset to 0 and updated every cycle.
  - Any difference between current inputs and `prev` acts as `req`: it starts a frame in IDLE, or sets `pending` in SEND.
  - A nonzero input right after reset therefore triggers one report.
- Not defined: no `prev` register. Reports start only from `req`.

## Test plan

- **Basic frame:** `digit_h`=12, `digit_l`=34, `dot`=1, `req` pulse, `fifo_full`=0.
  - Required: bytes 31 32 3A 33 34 0D 0A in 7 consecutive cycles.
  - Required: `busy` high for exactly 7 cycles.
- **Blank separator and saturation:** `digit_h`=0, `digit_l`=105, `dot`=0.
  - Required: bytes 30 30 20 39 39 0D 0A.
- **Backpressure:** `fifo_full`=1 for 3 cycles starting at byte 2.
  - Required: `fifo_wr`=0 during those cycles, with `fifo_wr_data` held at 3A.
  - Required: frame completes in 10 cycles with all 7 bytes correct.
- **Pending requests:** 3 `req` pulses during SEND, and inputs changed to 05/06 mid-frame.
  - Required: the first frame still reports the old values.
  - Required: after exactly 1 idle cycle, one second frame 30 35 3A 30 36 0D 0A.
  - Required: no third frame.
- **Reset mid-frame:** assert `reset` after byte 3.
  - Required: `fifo_wr`=0 and `busy`=0 the next cycle; no further bytes.
  - Required: the next `req` sends a full fresh frame.
- **Auto mode** (`UART_TIME_REPORT_AUTO_EN`): change `digit_l` 07→08 with no `req`.
  - Required: one frame ending in ...30 38 0D 0A.
  - Required: inputs held stable produce no further frames.
